// File: rtl/marquee_input_ctrl.sv
// Button front end for the LED marquee: per-button sync/debounce/press detect, plus the
// RUN/PAUSE control that sets direction and speed and paces the one-cycle advance strobe.
module marquee_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1_250_000,
  parameter int unsigned TICK_BASE    = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [3:0] btn_press,
  output logic       adv_tick,
  output logic       dir,
  output logic [1:0] speed,
  output logic       paused
);

  localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned TW = $clog2(8 * TICK_BASE);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [DW-1:0] DB_ZERO = DW'(0);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic [TW-1:0] T_ZERO  = TW'(0);
  localparam logic [TW-1:0] T_ONE   = TW'(1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_PAUSE = 1'b1;

  // Last count value of the advance period for a given speed level (slower = longer).
  function automatic logic [TW-1:0] tick_last(input logic [1:0] spd);
    case (spd)
      2'd3:    tick_last = TW'(TICK_BASE - 1);
      2'd2:    tick_last = TW'(2 * TICK_BASE - 1);
      2'd1:    tick_last = TW'(4 * TICK_BASE - 1);
      default: tick_last = TW'(8 * TICK_BASE - 1);
    endcase
  endfunction

  logic [3:0]    sync1_r;
  logic [3:0]    sync2_r;
  logic [3:0]    db_r;
  logic [3:0]    press_r;
  logic [DW-1:0] dcnt_r [4];

  logic [0:0]    state_r;
  logic          dir_r;
  logic [1:0]    speed_r;
  logic [TW-1:0] tcnt_r;
  logic          tick_r;

  logic [0:0]    state_s;
  logic          dir_s;
  logic [1:0]    speed_s;
  logic [TW-1:0] tcnt_s;
  logic          tick_s;
  logic          up_s;
  logic          dn_s;
  logic          spd_chg_s;

  // Synchronize the raw buttons, debounce each bit, and flag accepted 0->1 transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      db_r    <= 4'b0000;
      press_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        dcnt_r[i] <= DB_ZERO;
      end
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      for (int i = 0; i < 4; i++) begin
        press_r[i] <= 1'b0;
        if (sync2_r[i] == db_r[i]) begin
          dcnt_r[i] <= DB_ZERO;
        end else if (dcnt_r[i] == DB_LAST) begin
          db_r[i]    <= sync2_r[i];
          dcnt_r[i]  <= DB_ZERO;
          press_r[i] <= sync2_r[i];
        end else begin
          dcnt_r[i] <= dcnt_r[i] + DB_ONE;
        end
      end
    end
  end

  // Next-state logic for run/pause, direction, speed level and the advance timer.
  always_comb begin
    state_s   = state_r;
    dir_s     = dir_r;
    speed_s   = speed_r;
    tcnt_s    = tcnt_r;
    tick_s    = 1'b0;
    up_s      = press_r[1] & ~press_r[2];
    dn_s      = press_r[2] & ~press_r[1];
    spd_chg_s = (up_s && (speed_r != 2'd3)) || (dn_s && (speed_r != 2'd0));

    if (up_s && (speed_r != 2'd3)) begin
      speed_s = speed_r + 2'd1;
    end else if (dn_s && (speed_r != 2'd0)) begin
      speed_s = speed_r - 2'd1;
    end else begin
      speed_s = speed_r;
    end

    case (state_r)
      ST_RUN: begin
        if (press_r[0]) begin
          dir_s = ~dir_r;
        end else begin
          dir_s = dir_r;
        end
        // A pause request beats a period expiring in the same cycle.
        if (press_r[3]) begin
          state_s = ST_PAUSE;
          tcnt_s  = T_ZERO;
        end else if (spd_chg_s) begin
          tcnt_s = T_ZERO;
        end else if (tcnt_r == tick_last(speed_r)) begin
          tcnt_s = T_ZERO;
          tick_s = 1'b1;
        end else begin
          tcnt_s = tcnt_r + T_ONE;
        end
      end
      ST_PAUSE: begin
        tcnt_s = T_ZERO;
        tick_s = press_r[0];
        if (press_r[3]) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      default: begin
        state_s = ST_RUN;
        tcnt_s  = T_ZERO;
      end
    endcase
  end

  // Control state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
      dir_r   <= 1'b0;
      speed_r <= 2'd1;
      tcnt_r  <= T_ZERO;
      tick_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      dir_r   <= dir_s;
      speed_r <= speed_s;
      tcnt_r  <= tcnt_s;
      tick_r  <= tick_s;
    end
  end

  assign btn_press = press_r;
  assign adv_tick  = tick_r;
  assign dir       = dir_r;
  assign speed     = speed_r;
  assign paused    = (state_r == ST_PAUSE);

endmodule
